// File: rtl/normalize_cg2_seq.sv
// normalize_cg2_seq: iterative post-adder-tree normalizer.
// Converts a signed, max_exp-aligned partial-product sum to sign/magnitude,
// shifts the leading one to bit T = SUM_W-3 one step per cycle, adjusting the
// exponent, then rounds the mantissa to MAN_W bits and presents the result
// over a valid/ready handshake. One operation in flight.
//
// Optional build macro NORM_ROUND_RNE_EN: when defined, the ROUND state
// applies round-to-nearest-even; otherwise it truncates (no sticky tracking).
//
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_valid/o_ready    input handshake (o_ready high only while idle)
//   i_sum, i_max_exp   aligned two's-complement sum and its exponent
//   o_valid/i_ready    output handshake
//   o_sign, o_exp      result sign and normalized exponent
//   o_man, o_zero      rounded mantissa (MSB = leading one), exact-zero flag
module normalize_cg2_seq #(
  parameter int unsigned SUM_W = 16,
  parameter int unsigned EXP_W = 6,
  parameter int unsigned MAN_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [SUM_W-1:0] i_sum,
  input  logic [EXP_W-1:0] i_max_exp,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sign,
  output logic [EXP_W-1:0] o_exp,
  output logic [MAN_W-1:0] o_man,
  output logic             o_zero
);

  localparam int unsigned T = SUM_W - 3;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             sign_q, sign_d;
  logic             sat_q, sat_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             o_sign_q, o_sign_d;
  logic [EXP_W-1:0] o_exp_q, o_exp_d;
  logic [MAN_W-1:0] o_man_q, o_man_d;
  logic             o_zero_q, o_zero_d;
`ifdef NORM_ROUND_RNE_EN
  logic             sticky_q, sticky_d;
  logic             guard_c, sticky_c;
`endif

  logic             above_t_c;
  logic             rnd_up_c;
  logic [MAN_W:0]   man_inc_c;

  // Leading-one position relative to T
  assign above_t_c = |mag_q[SUM_W-1:T+1];

  // Rounding increment; the extra MSB of man_inc_c is the mantissa carry-out
`ifdef NORM_ROUND_RNE_EN
  assign guard_c  = mag_q[T-MAN_W];
  assign sticky_c = sticky_q | (|mag_q[T-MAN_W-1:0]);
  assign rnd_up_c = guard_c & (sticky_c | mag_q[T-MAN_W+1]);
`else
  assign rnd_up_c = 1'b0;
`endif
  assign man_inc_c = {1'b0, mag_q[T -: MAN_W]} + (MAN_W+1)'(rnd_up_c);

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sat_d    = sat_q;
    o_sign_d = o_sign_q;
    o_exp_d  = o_exp_q;
    o_man_d  = o_man_q;
    o_zero_d = o_zero_q;
`ifdef NORM_ROUND_RNE_EN
    sticky_d = sticky_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_valid && ready_q) begin
          sign_d = i_sum[SUM_W-1];
          exp_d  = i_max_exp;
          mag_d  = i_sum[SUM_W-1] ? (~i_sum + SUM_W'(1)) : i_sum;
          sat_d  = 1'b0;
`ifdef NORM_ROUND_RNE_EN
          sticky_d = 1'b0;
`endif
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mag_q == '0) begin
          o_zero_d = 1'b1;
          o_sign_d = 1'b0;
          o_exp_d  = '0;
          o_man_d  = '0;
          state_d  = S_OUT;
        end else if (above_t_c) begin
          // Growth: right shift unless the exponent would overflow
          if (exp_q == EXP_MAX) begin
            sat_d   = 1'b1;
            state_d = S_ROUND;
          end else begin
            mag_d = mag_q >> 1;
            exp_d = exp_q + EXP_W'(1);
`ifdef NORM_ROUND_RNE_EN
            sticky_d = sticky_q | mag_q[0];
`endif
          end
        end else if (!mag_q[T] && (exp_q > EXP_W'(1))) begin
          // Cancellation: left shift, stopping at exponent 1 (subnormal)
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        o_zero_d = 1'b0;
        o_sign_d = sign_q;
        if (sat_q || (man_inc_c[MAN_W] && (exp_q == EXP_MAX))) begin
          o_exp_d = EXP_MAX;
          o_man_d = '1;
        end else if (man_inc_c[MAN_W]) begin
          o_exp_d = exp_q + EXP_W'(1);
          o_man_d = {1'b1, {(MAN_W-1){1'b0}}};
        end else begin
          o_exp_d = exp_q;
          o_man_d = man_inc_c[MAN_W-1:0];
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (valid_q && i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_OUT);
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sat_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      o_sign_q <= 1'b0;
      o_exp_q  <= '0;
      o_man_q  <= '0;
      o_zero_q <= 1'b0;
`ifdef NORM_ROUND_RNE_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sat_q    <= sat_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      o_sign_q <= o_sign_d;
      o_exp_q  <= o_exp_d;
      o_man_q  <= o_man_d;
      o_zero_q <= o_zero_d;
`ifdef NORM_ROUND_RNE_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_sign  = o_sign_q;
  assign o_exp   = o_exp_q;
  assign o_man   = o_man_q;
  assign o_zero  = o_zero_q;

endmodule

// File: tb/tb_normalize_cg2_seq.sv
// Bench for normalize_cg2_seq: directed cases plus randomized sums checked
// against an arithmetic reference model of normalization and rounding.
module tb_normalize_cg2_seq;

  localparam int TT = 13;  // leading-one target for SUM_W=16

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_sum;
  logic [5:0]  i_max_exp;
  logic        o_valid;
  logic        i_ready;
  logic        o_sign;
  logic [5:0]  o_exp;
  logic [2:0]  o_man;
  logic        o_zero;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  normalize_cg2_seq dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_sum     (i_sum),
    .i_max_exp (i_max_exp),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_sign    (o_sign),
    .o_exp     (o_exp),
    .o_man     (o_man),
    .o_zero    (o_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: value-level normalization with explicit shift counts
  task automatic model(input logic [15:0] s, input logic [5:0] e,
                       output logic sg, output logic [5:0] ex,
                       output logic [2:0] mn, output logic zr, output int lat);
    int mag, p, r, l, v, ei, m;
    bit stk, g, st, sat;
    sg  = s[15];
    mag = sg ? (65536 - int'(s)) : int'(s);
    if (mag == 0) begin
      sg = 1'b0; ex = '0; mn = '0; zr = 1'b1; lat = 1;
      return;
    end
    zr = 1'b0; p = 0; ei = int'(e); stk = 0; sat = 0;
    for (int i = 0; i < 17; i++) if (((mag >> i) & 1) == 1) p = i;
    if (p > TT) begin
      r = p - TT;
      if (ei + r > 63) begin sat = 1; r = 63 - ei; end
      v   = mag >> r;
      stk = (mag & ((1 << r) - 1)) != 0;
      ei += r;
      lat = 2 + r;
    end else begin
      l = 0;
      if (ei > 1) l = ((TT - p) < (ei - 1)) ? (TT - p) : (ei - 1);
      v   = mag << l;
      ei -= l;
      lat = 2 + l;
    end
    if (sat) begin ex = 6'd63; mn = 3'd7; return; end
    m  = (v >> 11) & 7;
    g  = ((v >> 10) & 1) != 0;
    st = stk || ((v & 1023) != 0);
`ifdef NORM_ROUND_RNE_EN
    if (g && (st || (m % 2 == 1))) m++;
`endif
    if (m == 8) begin m = 4; ei++; end
    if (ei > 63) begin ei = 63; m = 7; end
    ex = 6'(ei);
    mn = 3'(m);
  endtask

  // One full transaction: accept, wait for result, hold, then hand off
  task automatic run_op(input logic [15:0] s, input logic [5:0] e, input int hold);
    logic sg, zr; logic [5:0] ex; logic [2:0] mn; int lat, cnt;
    model(s, e, sg, ex, mn, zr, lat);
    chk("ready_before_accept", 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_sum = s; i_max_exp = e;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    cnt = 0;
    while (!o_valid && cnt < 100) begin
      @(posedge i_clk); #1;
      cnt++;
    end
    if (cnt >= 100) begin
      chk("timeout_o_valid", 32'(o_valid), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "o_valid never asserted");
    end
    chk("latency", 32'(cnt), 32'(lat));
    chk("result", {19'd0, o_zero, o_sign, o_exp, o_man}, {19'd0, zr, sg, ex, mn});
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clk); #1;
      chk("hold", {17'd0, o_ready, o_valid, o_zero, o_sign, o_exp, o_man},
          {17'd0, 1'b0, 1'b1, zr, sg, ex, mn});
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk("after_handoff", {17'd0, o_ready, o_valid, o_zero, o_sign, o_exp, o_man},
        {17'd0, 1'b1, 1'b0, zr, sg, ex, mn});
  endtask

  initial begin
    logic [15:0] rs;
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_sum = '0; i_max_exp = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_state", {19'd0, o_ready, o_valid, o_zero, o_sign, o_exp, o_man},
        {19'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0});
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Leading one already at target
    run_op(16'h2000, 6'd10, 0);
    chk("p1_exp_man", {23'd0, o_sign, o_exp, o_man}, {23'd0, 1'b0, 6'd10, 3'b100});
    run_op(16'hE000, 6'd10, 1);
    chk("p2_neg", {23'd0, o_sign, o_exp, o_man}, {23'd0, 1'b1, 6'd10, 3'b100});
    // Three left shifts
    run_op(16'h0400, 6'd10, 0);
    chk("p2_left", {23'd0, o_sign, o_exp, o_man}, {23'd0, 1'b0, 6'd7, 3'b100});
    // One right shift
    run_op(16'h4000, 6'd10, 0);
    chk("p3_right", {23'd0, o_sign, o_exp, o_man}, {23'd0, 1'b0, 6'd11, 3'b100});
    // Rounding carry-out vs truncation
    run_op(16'h3C00, 6'd10, 0);
`ifdef NORM_ROUND_RNE_EN
    chk("p3_round", {23'd0, o_sign, o_exp, o_man}, {23'd0, 1'b0, 6'd11, 3'b100});
`else
    chk("p3_trunc", {23'd0, o_sign, o_exp, o_man}, {23'd0, 1'b0, 6'd10, 3'b111});
`endif
    // Subnormal stop and exponent saturation
    run_op(16'h0001, 6'd3, 0);
    chk("p4_subnormal", {22'd0, o_zero, o_sign, o_exp, o_man}, {22'd0, 1'b0, 1'b0, 6'd1, 3'b000});
    run_op(16'h7FFF, 6'd63, 0);
    chk("p4_saturate", {23'd0, o_sign, o_exp, o_man}, {23'd0, 1'b0, 6'd63, 3'b111});
    run_op(16'h8000, 6'd20, 0);
    chk("most_negative", {23'd0, o_sign, o_exp, o_man}, {23'd0, 1'b1, 6'd22, 3'b100});
    // Exact zero with back-pressure
    run_op(16'h0000, 6'd17, 5);
    chk("p5_zero", {22'd0, o_zero, o_sign, o_exp, o_man}, {22'd0, 1'b1, 1'b0, 6'd0, 3'd0});

    // Reset during NORM aborts the operation
    i_valid = 1'b1; i_sum = 16'h0001; i_max_exp = 6'd10;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    chk("p6_reset_abort", {30'd0, o_ready, o_valid}, {30'd0, 1'b1, 1'b0});
    i_rst_n = 1'b1;
    repeat (20) begin
      @(posedge i_clk); #1;
      chk("p6_no_stale_valid", 32'(o_valid), 32'd0);
    end
    run_op(16'h2000, 6'd5, 0);
    chk("p6_after_reset", {23'd0, o_sign, o_exp, o_man}, {23'd0, 1'b0, 6'd5, 3'b100});

    // Randomized sums across magnitudes, signs and exponents
    for (int n = 0; n < 80; n++) begin
      rs = 16'($urandom);
      rs = rs >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) rs = ~rs + 16'd1;
      if ($urandom_range(0, 3) == 0)
        run_op(rs, 6'($urandom_range(60, 63)), $urandom_range(0, 2));
      else
        run_op(rs, 6'($urandom_range(0, 63)), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
